fifo_ring: RTL and testbench

- Parametrised circular-buffer FIFO with read/write pointers; no data shifting.
- Data width, depth (any value ≥2, not limited to powers of two) and read mode are configurable.
- Adds a fill level, programmable almost-full/almost-empty flags, synchronous flush, and push+pop on a full FIFO.
- General-purpose buffer between producer/consumer blocks sharing one clock, e.g. UART TX/RX staging.

---
 rtl/fifo_ring.sv | 163 ++++++++++++++++
 tb/tb_fifo_ring.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ring.sv
// Circular-buffer FIFO with fill level, almost-full/empty flags, synchronous flush
// and registered or show-ahead read. Define FIFO_RING_ERR_EN for sticky overflow/underflow outputs.
module fifo_ring #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 1,
  parameter int FWFT         = 0
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         pop,
  output logic [WIDTH-1:0]             data_out,
  output logic                         data_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef FIFO_RING_ERR_EN
  ,
  output logic                         overflow,
  output logic                         underflow
`endif
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_ring: DEPTH must be at least 2");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("fifo_ring: AFULL_LEVEL must lie in 1..DEPTH");
  end
  if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL >= DEPTH) begin : g_bad_aempty
    $error("fifo_ring: AEMPTY_LEVEL must lie in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             empty_w, full_w, pop_ok, push_ok;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_w = (level_q == '0);
  assign full_w  = (level_q == LVL_W'(DEPTH));
  assign pop_ok  = pop && !empty_w;
  assign push_ok = push && (!full_w || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out   = empty_w ? '0 : mem_q[rd_ptr_q];
    assign data_valid = !empty_w;
  end else begin : g_reg_read
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (flush) begin
        rdata_d = '0;
      end else if (pop_ok) begin
        rdata_d  = mem_q[rd_ptr_q];
        rvalid_d = 1'b1;
      end
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign data_out   = rdata_q;
    assign data_valid = rvalid_q;
  end

`ifdef FIFO_RING_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Flush clears the sticky flags even when a drop happens in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (push && !push_ok) ovf_d = 1'b1;
      if (pop && !pop_ok)   udf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

  assign level        = level_q;
  assign empty        = empty_w;
  assign full         = full_w;
  assign almost_full  = (level_q >= LVL_W'(AFULL_LEVEL));
  assign almost_empty = (level_q <= LVL_W'(AEMPTY_LEVEL));

endmodule

// File: tb/tb_fifo_ring.sv
// Bench for fifo_ring: a registered-read and a show-ahead instance (DEPTH=5) share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_fifo_ring;

  localparam int W = 8;
  localparam int D = 5;
  localparam int AF = D - 2;
  localparam int AE = 1;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         flush = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] data_in = '0;

  logic [W-1:0] do0, do1;
  logic         dv0, dv1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic [2:0]   lvl0, lvl1;
`ifdef FIFO_RING_ERR_EN
  logic         ovf0, ovf1, udf0, udf1;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] m_do0;
  logic         m_dv0;
  logic         m_ovf, m_udf;

  always #5 clock = ~clock;

  fifo_ring #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_reg (
    .clock(clock), .resetn(resetn), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
    .data_out(do0), .data_valid(dv0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .level(lvl0)
`ifdef FIFO_RING_ERR_EN
    , .overflow(ovf0), .underflow(udf0)
`endif
  );

  fifo_ring #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clock(clock), .resetn(resetn), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
    .data_out(do1), .data_valid(dv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .level(lvl1)
`ifdef FIFO_RING_ERR_EN
    , .overflow(ovf1), .underflow(udf1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_do0 = '0;
    m_dv0 = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_cycle(input logic pu, input logic [W-1:0] d, input logic po, input logic fl);
    bit pop_ok, push_ok;
    logic [W-1:0] head;
    if (fl) begin
      model_reset();
      return;
    end
    pop_ok  = po && (mq.size() > 0);
    push_ok = pu && ((mq.size() < D) || pop_ok);
    m_dv0 = pop_ok;
    if (pop_ok) begin
      head  = mq.pop_front();
      m_do0 = head;
    end
    if (push_ok) mq.push_back(d);
    if (pu && !push_ok) m_ovf = 1'b1;
    if (po && !pop_ok)  m_udf = 1'b1;
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("level", 32'(lvl0), 32'(n));
    chk("level_fwft", 32'(lvl1), 32'(n));
    chk("full", 32'(full0), 32'(n == D));
    chk("empty", 32'(empty0), 32'(n == 0));
    chk("almost_full", 32'(af0), 32'(n >= AF));
    chk("almost_empty", 32'(ae0), 32'(n <= AE));
    chk("data_valid", 32'(dv0), 32'(m_dv0));
    chk("data_out", 32'(do0), 32'(m_do0));
    chk("data_valid_fwft", 32'(dv1), 32'(n > 0));
    chk("data_out_fwft", 32'(do1), (n > 0) ? 32'(mq[0]) : 32'h0);
`ifdef FIFO_RING_ERR_EN
    chk("overflow", 32'(ovf0), 32'(m_ovf));
    chk("underflow", 32'(udf0), 32'(m_udf));
    chk("overflow_fwft", 32'(ovf1), 32'(m_ovf));
    chk("underflow_fwft", 32'(udf1), 32'(m_udf));
`endif
  endtask

  // One clock cycle: drive, model the edge, sample #1 after it.
  task automatic step(input logic pu, input logic [W-1:0] d, input logic po, input logic fl);
    push = pu; data_in = d; pop = po; flush = fl;
    @(posedge clock);
    model_cycle(pu, d, po, fl);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    resetn = 1'b1;

    // Fill 0x11..0x15 then drain in order
    for (int i = 0; i < D; i++) step(1'b1, W'(8'h11 + i), 1'b0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Wrap-around past index 4
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < D; i++) step(1'b1, W'(8'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Push+pop on full, then a dropped push on full
    for (int i = 0; i < D; i++) step(1'b1, W'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Push+pop on empty, then pop on empty
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Show-ahead sequence 0x55, 0x66
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with push at level 3, and flush coinciding with a dropped push/pop
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < D; i++) step(1'b1, W'(8'hD0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEF, 1'b0, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'hF1 + i), 1'b0, 1'b0);
    step(1'b1, 8'hF4, 1'b1, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    resetn = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
